regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001: Parameter DATAW, default 32, width of every data bus.
REQ-002: Parameter ADDRW, default 5, register address width.
REQ-003: Parameter CNTW, default 16, conflict counter width.
REQ-004: clock  input  1  sole clock; all state updates on its rising edge.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: req0_valid / req0_addr / req0_data  input  1 / ADDRW / DATAW  writeback request from requester 0 (ALU).
REQ-007: req0_ready  output  1  request 0 accepted this cycle.
REQ-008: req1_valid / req1_addr / req1_data  input  1 / ADDRW / DATAW  writeback request from requester 1 (load unit).
REQ-009: req1_ready  output  1  request 1 accepted this cycle.
REQ-010: wb_enable / wb_addr / wb_data  output  1 / ADDRW / DATAW  registered write port driving the register file.
REQ-011: rs1_addr, rs2_addr  input  ADDRW each  read addresses presented to the register file.
REQ-012: rf_rs1_data, rf_rs2_data  input  DATAW each  raw register-file read data.
REQ-013: rs1_data, rs2_data  output  DATAW each  bypassed read data.
REQ-014: conflict_cnt  output  CNTW  count of cycles in which both requesters were valid.

Function
REQ-015: A request SHALL transfer only in a cycle where its valid and ready are both 1; a requester holds valid, addr and data stable until accepted.
REQ-016: At most one ready SHALL be 1 per cycle; ready is combinational from both valids and the last-grant pointer.
REQ-017: Only one valid -> that requester SHALL be granted in the same cycle.
REQ-018: Both valid -> the requester not granted most recently SHALL be granted (round-robin).
REQ-019: The last-grant pointer SHALL update only in cycles with a grant and hold otherwise.
REQ-020: Latency SHALL be one cycle: a grant in cycle N drives wb_enable/wb_addr/wb_data in cycle N+1.
REQ-021: wb_enable SHALL be 1 in cycle N+1 only if a grant occurred in cycle N and the granted addr != 0.
REQ-022: A granted request with addr 0 SHALL be accepted (ready 1) and dropped (wb_enable 0).
REQ-023: wb_addr and wb_data SHALL load on every grant and hold their value otherwise.
REQ-024: rsX_data SHALL equal wb_data when wb_enable = 1 and wb_addr = rsX_addr, else rf_rsX_data, for X = 1, 2 independently; purely combinational.
REQ-025: Because wb_enable excludes x0, reads of address 0 SHALL never be bypassed.
REQ-026: conflict_cnt SHALL increment by 1 in each cycle with req0_valid = req1_valid = 1 and saturate at all-ones.

Reset
REQ-027: While reset = 1, req0_ready and req1_ready SHALL be 0 and no request is accepted.
REQ-028: On a clock edge with reset = 1: wb_enable, wb_addr, wb_data and conflict_cnt SHALL be 0, and the last-grant pointer SHALL point to requester 1, so requester 0 wins the first tie.
REQ-029: Reset asserted mid-operation SHALL discard the in-flight write: wb_enable is 0 in the cycle after the reset edge.

Structure
REQ-030: A shared package SHALL hold DATAW, ADDRW, NUM_REGS (32), the x0 address constant and the requester-id type.
REQ-031: Round-robin grant logic and its pointer SHALL be one sub-module, rr_arbiter2; the writeback register, bypass muxes and counter stay in the top.

Verification
REQ-032: Tie: after reset, req0 (addr 5, 0xAAAA0000) and req1 (addr 6, 0x5555) both held valid -> req0 granted in cycle 0 and req1 in cycle 1; wb shows (5, 0xAAAA0000) in cycle 1 and (6, 0x5555) in cycle 2; conflict_cnt = 1.
REQ-033: x0 drop: req1 valid with addr 0, data 0xDEADBEEF -> req1_ready = 1, and wb_enable = 0 next cycle.
REQ-034: Bypass: wb_enable = 1, wb_addr = 7, wb_data = 0x1234, rs1_addr = 7, rs2_addr = 8, rf_rs1_data = 0, rf_rs2_data = 0x99 -> rs1_data = 0x1234, rs2_data = 0x99.
REQ-035: Saturation: CNTW = 4, both requesters valid for 20 cycles -> conflict_cnt reaches 0xF and holds.
REQ-036: Reset mid-op: grant req0 (addr 3) in cycle N with reset = 1 in cycle N -> no ready, wb_enable = 0 in cycle N+1, and the next tie goes to req0.
REQ-037: Alternation: only req1 valid for 3 transfers, then both valid -> req0 granted first.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_wb_arbiter_pkg;

    // Default bus widths and register-file geometry.
    localparam int DATAW    = 32;
    localparam int ADDRW    = 5;
    localparam int NUM_REGS = 32;

    // Register x0 is hardwired to zero: writes to it are dropped and reads are never bypassed.
    localparam logic [ADDRW-1:0] X0_ADDR = '0;

    // Identifies one of the two writeback requesters.
    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_t;

    // Returns the opposite requester; used to alternate on a tie.
    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_ALU) ? REQ_LOAD : REQ_ALU;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with a last-grant pointer.
// Latency: grant is combinational from the valids in the same cycle; the pointer updates on the next edge.
// Backpressure: at most one grant per cycle; no grant while reset is high.
module rr_arbiter2 (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [1:0]                          req_valid,
    output logic [1:0]                          grant,
    output regfile_wb_arbiter_pkg::req_id_t     grant_id
);
    import regfile_wb_arbiter_pkg::*;

    // Requester that won the most recent grant; a tie goes to the other one.
    req_id_t last_id;

    // Pick the winner: a lone valid wins outright, a tie goes to whoever did not win last.
    always_comb begin
        grant    = 2'b00;
        grant_id = REQ_ALU;
        if (!reset) begin
            case (req_valid)
                2'b01: begin
                    grant_id = REQ_ALU;
                    grant    = 2'b01;
                end
                2'b10: begin
                    grant_id = REQ_LOAD;
                    grant    = 2'b10;
                end
                2'b11: begin
                    grant_id = other_req(last_id);
                    grant    = (other_req(last_id) == REQ_LOAD) ? 2'b10 : 2'b01;
                end
                default: begin
                    grant_id = REQ_ALU;
                    grant    = 2'b00;
                end
            endcase
        end
    end

    // Remember the last winner; reset points at the load unit so the ALU wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_id <= REQ_LOAD;
        end else if (|grant) begin
            last_id <= grant_id;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two writeback requesters onto one register-file write port, bypasses reads, counts conflicts.
// Latency: one cycle from grant to wb_enable/wb_addr/wb_data; bypass muxes are combinational.
// Backpressure: ready is combinational from both valids; the loser of a tie holds its request until granted.
module regfile_wb_arbiter #(
    parameter int DATAW = regfile_wb_arbiter_pkg::DATAW,
    parameter int ADDRW = regfile_wb_arbiter_pkg::ADDRW,
    parameter int CNTW  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [ADDRW-1:0] req0_addr,
    input  logic [DATAW-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [ADDRW-1:0] req1_addr,
    input  logic [DATAW-1:0] req1_data,
    output logic             req1_ready,
    output logic             wb_enable,
    output logic [ADDRW-1:0] wb_addr,
    output logic [DATAW-1:0] wb_data,
    input  logic [ADDRW-1:0] rs1_addr,
    input  logic [ADDRW-1:0] rs2_addr,
    input  logic [DATAW-1:0] rf_rs1_data,
    input  logic [DATAW-1:0] rf_rs2_data,
    output logic [DATAW-1:0] rs1_data,
    output logic [DATAW-1:0] rs2_data,
    output logic [CNTW-1:0]  conflict_cnt
);
    import regfile_wb_arbiter_pkg::*;

    // One writeback transaction: destination register and value.
    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [DATAW-1:0] data;
    } wb_req_t;

    localparam logic [ADDRW-1:0] ZERO_REG = ADDRW'(X0_ADDR);

    logic [1:0] req_valid;
    logic [1:0] grant;
    req_id_t    grant_id;
    logic       grant_any;
    logic       both_valid;
    wb_req_t    req0_pkt;
    wb_req_t    req1_pkt;
    wb_req_t    gnt_pkt;
    wb_req_t    wb_pkt;

    assign req_valid  = {req1_valid, req0_valid};
    assign both_valid = req0_valid & req1_valid;
    assign req0_pkt   = '{addr: req0_addr, data: req0_data};
    assign req1_pkt   = '{addr: req1_addr, data: req1_data};

    rr_arbiter2 u_arb (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign grant_any  = |grant;

    // Select the payload of whichever requester won this cycle.
    always_comb begin
        gnt_pkt = req0_pkt;
        if (grant_id == REQ_LOAD) begin
            gnt_pkt = req1_pkt;
        end
    end

    // Register the granted write; x0 writes are accepted but never enable the port.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_enable <= 1'b0;
            wb_pkt    <= '0;
        end else begin
            wb_enable <= grant_any && (gnt_pkt.addr != ZERO_REG);
            if (grant_any) begin
                wb_pkt <= gnt_pkt;
            end
        end
    end

    assign wb_addr = wb_pkt.addr;
    assign wb_data = wb_pkt.data;

    // Count cycles where both requesters compete, saturating at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (both_valid && (conflict_cnt != {CNTW{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    // Forward the pending write to each read port independently; x0 never matches since wb_enable excludes it.
    always_comb begin
        rs1_data = rf_rs1_data;
        rs2_data = rf_rs2_data;
        if (wb_enable && (wb_addr == rs1_addr)) begin
            rs1_data = wb_data;
        end
        if (wb_enable && (wb_addr == rs2_addr)) begin
            rs2_data = wb_data;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for the writeback arbiter: directed scenarios then randomized traffic against a reference model.
// Latency: model predicts writes one cycle after each grant.
// Backpressure: requesters hold valid/addr/data until accepted.
module tb_regfile_wb_arbiter;

    localparam int DATAW   = 32;
    localparam int ADDRW   = 5;
    localparam int CNTW    = 4;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req0_valid = 1'b0;
    logic [ADDRW-1:0] req0_addr = '0;
    logic [DATAW-1:0] req0_data = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [ADDRW-1:0] req1_addr = '0;
    logic [DATAW-1:0] req1_data = '0;
    logic             req1_ready;
    logic             wb_enable;
    logic [ADDRW-1:0] wb_addr;
    logic [DATAW-1:0] wb_data;
    logic [ADDRW-1:0] rs1_addr = '0;
    logic [ADDRW-1:0] rs2_addr = '0;
    logic [DATAW-1:0] rf_rs1_data = '0;
    logic [DATAW-1:0] rf_rs2_data = '0;
    logic [DATAW-1:0] rs1_data;
    logic [DATAW-1:0] rs2_data;
    logic [CNTW-1:0]  conflict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who won last (1 = requester 1), the pending write, and the conflict count.
    int               m_last_winner;
    bit               m_wb_en;
    logic [ADDRW-1:0] m_wb_addr;
    logic [DATAW-1:0] m_wb_data;
    int               m_cnt;

    regfile_wb_arbiter #(
        .DATAW (DATAW),
        .ADDRW (ADDRW),
        .CNTW  (CNTW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .wb_enable    (wb_enable),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rf_rs1_data  (rf_rs1_data),
        .rf_rs2_data  (rf_rs2_data),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_winner = 1;
        m_wb_en       = 1'b0;
        m_wb_addr     = '0;
        m_wb_data     = '0;
        m_cnt         = 0;
    endtask

    function automatic logic [ADDRW-1:0] rand_addr();
        return ($urandom_range(0, 5) == 0) ? '0 : ADDRW'($urandom);
    endfunction

    // Update requester inputs after an edge. mode 0: drop accepted requests; 1: random traffic; 2: keep both busy.
    task automatic drive(input int mode, input bit g0, input bit g1);
        if (mode == 0) begin
            if (g0) req0_valid = 1'b0;
            if (g1) req1_valid = 1'b0;
        end else if (mode == 2) begin
            if (g0) begin req0_addr = ADDRW'($urandom_range(1, 31)); req0_data = $urandom; end
            if (g1) begin req1_addr = ADDRW'($urandom_range(1, 31)); req1_data = $urandom; end
            req0_valid = 1'b1;
            req1_valid = 1'b1;
        end else begin
            if (g0 || !req0_valid) begin
                req0_valid = ($urandom_range(0, 99) < 60);
                req0_addr  = rand_addr();
                req0_data  = $urandom;
            end
            if (g1 || !req1_valid) begin
                req1_valid = ($urandom_range(0, 99) < 60);
                req1_addr  = rand_addr();
                req1_data  = $urandom;
            end
            reset       = ($urandom_range(0, 49) == 0);
            rs1_addr    = $urandom_range(0, 1) ? m_wb_addr : ADDRW'($urandom);
            rs2_addr    = $urandom_range(0, 1) ? m_wb_addr : ADDRW'($urandom);
            rf_rs1_data = $urandom;
            rf_rs2_data = $urandom;
        end
    endtask

    // One clock cycle: check every output mid-cycle against the model, advance the model across the edge.
    task automatic step(input int mode);
        bit               g0, g1, v0, v1, rst;
        logic [ADDRW-1:0] a0, a1, wa;
        logic [DATAW-1:0] d0, d1;
        logic [DATAW-1:0] exp1, exp2;
        @(negedge clock);
        v0 = req0_valid; v1 = req1_valid; rst = reset;
        a0 = req0_addr;  a1 = req1_addr;
        d0 = req0_data;  d1 = req1_data;
        g0 = 1'b0; g1 = 1'b0;
        if (!rst) begin
            if (v0 && v1) begin
                if (m_last_winner == 1) g0 = 1'b1; else g1 = 1'b1;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        exp1 = (m_wb_en && m_wb_addr == rs1_addr) ? m_wb_data : rf_rs1_data;
        exp2 = (m_wb_en && m_wb_addr == rs2_addr) ? m_wb_data : rf_rs2_data;
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("wb_enable", wb_enable, m_wb_en);
        chk("wb_addr", wb_addr, m_wb_addr);
        chk("wb_data", wb_data, m_wb_data);
        chk("conflict_cnt", conflict_cnt, m_cnt);
        chk("rs1_data", rs1_data, exp1);
        chk("rs2_data", rs2_data, exp2);
        @(posedge clock);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (v0 && v1) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (g0 || g1) begin
                wa            = g0 ? a0 : a1;
                m_wb_addr     = wa;
                m_wb_data     = g0 ? d0 : d1;
                m_wb_en       = (wa != 0);
                m_last_winner = g0 ? 0 : 1;
            end else begin
                m_wb_en = 1'b0;
            end
        end
        drive(mode, g0, g1);
    endtask

    initial begin
        // Bring the design to a known state before any check.
        @(posedge clock);
        #1;
        model_reset();

        // Readies stay low under reset even with both requesters valid.
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hAAAA0000;
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h00005555;
        step(0);
        step(0);

        // First tie after reset goes to requester 0, then requester 1.
        reset = 1'b0;
        #1;
        chk("tie_c0_rdy0", req0_ready, 1);
        chk("tie_c0_rdy1", req1_ready, 0);
        step(0);
        chk("tie_c1_wb_en", wb_enable, 1);
        chk("tie_c1_wb_addr", wb_addr, 5);
        chk("tie_c1_wb_data", wb_data, 32'hAAAA0000);
        chk("tie_c1_rdy1", req1_ready, 1);
        step(0);
        chk("tie_c2_wb_addr", wb_addr, 6);
        chk("tie_c2_wb_data", wb_data, 32'h00005555);
        chk("tie_cnt", conflict_cnt, 1);
        step(0);

        // A write to x0 is accepted but never reaches the write port.
        req1_valid = 1'b1; req1_addr = '0; req1_data = 32'hDEADBEEF;
        #1;
        chk("x0_rdy1", req1_ready, 1);
        step(0);
        chk("x0_wb_en", wb_enable, 0);

        // Bypass: only the read port addressing the pending register sees the new value.
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h00001234;
        step(0);
        rs1_addr = 5'd7; rs2_addr = 5'd8; rf_rs1_data = '0; rf_rs2_data = 32'h99;
        #1;
        chk("byp_rs1", rs1_data, 32'h00001234);
        chk("byp_rs2", rs2_data, 32'h99);
        rs1_addr = '0;
        #1;
        chk("byp_x0_read", rs1_data, 0);
        step(0);

        // Saturation: twenty cycles of contention pin the 4-bit counter at 0xF.
        req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = $urandom;
        req1_valid = 1'b1; req1_addr = 5'd10; req1_data = $urandom;
        for (int i = 0; i < 20; i++) step(2);
        chk("sat_cnt", conflict_cnt, 4'hF);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(0);

        // Reset in the grant cycle suppresses the grant and the write; next tie goes to requester 0.
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
        reset = 1'b1;
        #1;
        chk("rst_mid_rdy0", req0_ready, 0);
        step(0);
        chk("rst_mid_wb_en", wb_enable, 0);
        chk("rst_mid_cnt", conflict_cnt, 0);
        reset = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
        #1;
        chk("rst_tie_rdy0", req0_ready, 1);
        step(0);
        step(0);
        step(0);

        // After three lone transfers from requester 1, the next tie goes to requester 0.
        for (int i = 0; i < 3; i++) begin
            req1_valid = 1'b1; req1_addr = ADDRW'(i + 12); req1_data = $urandom;
            step(0);
        end
        req0_valid = 1'b1; req0_addr = 5'd20; req0_data = $urandom;
        req1_valid = 1'b1; req1_addr = 5'd21; req1_data = $urandom;
        #1;
        chk("alt_rdy0", req0_ready, 1);
        chk("alt_rdy1", req1_ready, 0);
        step(0);
        step(0);
        step(0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
